// File: rtl/i2s_defs.sv
// Shared definitions for the I2S receiver: FSM encoding, default word width
// and the bit-counter width helper.
package i2s_defs;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } rx_state_e;

  // The counter has to reach SAMPLE_W itself so that it can saturate there.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/i2s_bit_sampler.sv
// Registers the I2S pins into the clk domain, flags bclk rising edges as bit
// events and detects word boundaries against the word select seen last event.
module i2s_bit_sampler (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bclk_i,
  input  logic lrclk_i,
  input  logic sdin_i,
  output logic bit_evt_o,
  output logic bit_o,
  output logic lr_o,
  output logic boundary_o
);

  logic bclk_q;
  logic bclk2_q;
  logic lrclk_q;
  logic sdin_q;
  logic lr_prev_q;
  logic bit_evt;

  assign bit_evt = bclk_q & ~bclk2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_q    <= 1'b0;
      bclk2_q   <= 1'b0;
      lrclk_q   <= 1'b0;
      sdin_q    <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      bclk_q  <= bclk_i;
      bclk2_q <= bclk_q;
      lrclk_q <= lrclk_i;
      sdin_q  <= sdin_i;
      if (bit_evt) begin
        lr_prev_q <= lrclk_q;
      end
    end
  end

  assign bit_evt_o  = bit_evt;
  assign bit_o      = sdin_q;
  assign lr_o       = lrclk_q;
  // With the one-bit I2S delay the boundary bit still belongs to the old slot.
  assign boundary_o = bit_evt & (lrclk_q ^ lr_prev_q);

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: frames serial data into left/right words and presents stereo
// pairs on a valid/ready interface, flagging pairs dropped for lack of space.
module i2s_rx
  import i2s_defs::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic                sdin,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam int CW = cnt_width(SAMPLE_W);

  logic bit_evt;
  logic bit_val;
  logic lr_now;
  logic boundary;

  i2s_bit_sampler u_sampler (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .bclk_i     (bclk),
    .lrclk_i    (lrclk),
    .sdin_i     (sdin),
    .bit_evt_o  (bit_evt),
    .bit_o      (bit_val),
    .lr_o       (lr_now),
    .boundary_o (boundary)
  );

  rx_state_e           state_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [CW-1:0]       cnt_q;
  logic [SAMPLE_W-1:0] hold_q;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;
  logic                valid_q;
  logic                overrun_q;

  logic [SAMPLE_W-1:0] word_d;
  logic [CW-1:0]       cnt_d;
  logic                commit_d;

  // Bits land directly at their MSB-first position in a cleared register, so a
  // short word is already left-justified; a shift by SAMPLE_W drops the bit.
  assign word_d   = shift_q | ({bit_val, {(SAMPLE_W-1){1'b0}}} >> cnt_q);
  assign cnt_d    = (cnt_q == CW'(SAMPLE_W)) ? cnt_q : cnt_q + CW'(1);
  assign commit_d = enable && (state_q == ST_RIGHT) && boundary && !lr_now;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      // Output handshake runs regardless of enable so a pending pair survives.
      if (commit_d) begin
        if (!valid_q || out_ready) begin
          left_q  <= hold_q;
          right_q <= word_d;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      if (!enable) begin
        state_q <= ST_IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SYNC;
            shift_q <= '0;
            cnt_q   <= '0;
          end
          ST_SYNC: begin
            if (boundary && !lr_now) begin
              state_q <= ST_LEFT;
              shift_q <= '0;
              cnt_q   <= '0;
            end
          end
          ST_LEFT: begin
            if (boundary && lr_now) begin
              hold_q  <= word_d;
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= ST_RIGHT;
            end else if (bit_evt) begin
              shift_q <= word_d;
              cnt_q   <= cnt_d;
            end
          end
          ST_RIGHT: begin
            if (boundary && !lr_now) begin
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= ST_LEFT;
            end else if (bit_evt) begin
              shift_q <= word_d;
              cnt_q   <= cnt_d;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames with the one-bit data delay and
// checks committed pairs, handshake, overrun, reset and enable behaviour.
module tb_i2s_rx;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic        sdin;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  i2s_rx #(.SAMPLE_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdin      (sdin),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic        carry    = 1'b0;

  // Monitor: accepted pairs, cycles with valid high, cycles with overrun high.
  int          acc_cnt  = 0;
  int          vhi_cnt  = 0;
  int          ovr_cnt  = 0;
  logic [15:0] cap_l    = '0;
  logic [15:0] cap_r    = '0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      acc_cnt = acc_cnt + 1;
      cap_l   = out_left;
      cap_r   = out_right;
    end
    if (out_valid) vhi_cnt = vhi_cnt + 1;
    if (overrun)   ovr_cnt = ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit: 2 clk low (data/ws change), 2 clk high. Returns on the edge after
  // the rising edge of bclk, i.e. the edge where the DUT sees the bit event.
  task automatic send_bit(input logic lr, input logic d);
    @(posedge clk); #1;
    bclk = 1'b0; lrclk = lr; sdin = d;
    @(posedge clk);
    @(posedge clk); #1;
    bclk = 1'b1;
    @(posedge clk);
  endtask

  // A slot of n bclks: first bit is the LSB left over from the previous slot.
  task automatic send_slot(input logic lr, input logic [31:0] data, input int n, input bit chk);
    for (int j = 0; j < n; j++) begin
      send_bit(lr, (j == 0) ? carry : data[n-j]);
      if (chk && j == 0) begin
        #1;
        check("latency_edge1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_edge2_valid", 32'(out_valid), 32'd1);
      end
    end
    carry = data[0];
  endtask

  int acc0, vhi0, ovr0;
  logic [31:0] pdata;

  initial begin
    resetn = 1'b0; enable = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_left",    32'(out_left),  32'h0);
    check("reset_right",   32'(out_right), 32'h0);
    check("reset_valid",   32'(out_valid), 32'h0);
    check("reset_overrun", 32'(overrun),   32'h0);
    resetn = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);

    // 16 bclk/channel, ready high
    acc0 = acc_cnt; vhi0 = vhi_cnt; ovr0 = ovr_cnt;
    send_slot(1'b1, 32'h0000, 16, 1'b0);
    send_slot(1'b0, 32'hA55A, 16, 1'b0);
    send_slot(1'b1, 32'h3C3C, 16, 1'b0);
    send_slot(1'b0, 32'hA55A, 16, 1'b1);
    send_slot(1'b1, 32'h3C3C, 16, 1'b0);
    send_slot(1'b0, 32'hA55A, 16, 1'b0);
    check("full_accepts",   32'(acc_cnt - acc0), 32'd2);
    check("full_valid_cyc", 32'(vhi_cnt - vhi0), 32'd2);
    check("full_left",      32'(cap_l), 32'hA55A);
    check("full_right",     32'(cap_r), 32'h3C3C);
    check("full_no_ovr",    32'(ovr_cnt - ovr0), 32'd0);

    // 24 bclk/channel: extra bits ignored
    send_slot(1'b1, 32'h3C3C,   16, 1'b0);
    send_slot(1'b0, 32'h1234FF, 24, 1'b0);
    send_slot(1'b1, 32'hC3C3AA, 24, 1'b0);
    send_slot(1'b0, 32'hA5,      8, 1'b0);
    check("long_left",  32'(cap_l), 32'h1234);
    check("long_right", 32'(cap_r), 32'hC3C3);

    // 8 bclk/channel: left-justified, zero LSBs
    send_slot(1'b1, 32'h5A, 8, 1'b0);
    send_slot(1'b0, 32'h11, 8, 1'b0);
    check("short_left",  32'(cap_l), 32'hA500);
    check("short_right", 32'(cap_r), 32'h5A00);

    // backpressure for two frames
    out_ready = 1'b0;
    acc0 = acc_cnt; ovr0 = ovr_cnt;
    send_slot(1'b1, 32'h22, 8, 1'b0);
    send_slot(1'b0, 32'h33, 8, 1'b0);
    send_slot(1'b1, 32'h44, 8, 1'b0);
    send_slot(1'b0, 32'h55, 8, 1'b0);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_left_held",  32'(out_left),  32'h1100);
    check("bp_right_held", 32'(out_right), 32'h2200);
    check("bp_overrun_1",  32'(ovr_cnt - ovr0), 32'd1);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept_valid", 32'(out_valid), 32'd0);
    check("bp_accept_cnt",   32'(acc_cnt - acc0), 32'd1);
    check("bp_accept_left",  32'(cap_l), 32'h1100);
    check("bp_accept_right", 32'(cap_r), 32'h2200);

    // reset mid-left-word with a pair pending
    out_ready = 1'b0;
    send_slot(1'b1, 32'h66, 8, 1'b0);
    pdata = 32'h77;
    send_bit(1'b0, carry);
    for (int j = 1; j < 4; j++) send_bit(1'b0, pdata[8-j]);
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_left",  32'(out_left),  32'h5500);
    #1 resetn = 1'b0;
    #1;
    check("async_reset_left",    32'(out_left),  32'h0);
    check("async_reset_right",   32'(out_right), 32'h0);
    check("async_reset_valid",   32'(out_valid), 32'h0);
    check("async_reset_overrun", 32'(overrun),   32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    carry = 1'b0;
    acc0 = acc_cnt;
    send_slot(1'b0, 32'h77, 8, 1'b0);
    send_slot(1'b1, 32'h88, 8, 1'b0);
    send_slot(1'b0, 32'h99, 8, 1'b0);
    send_slot(1'b1, 32'hAA, 8, 1'b0);
    check("rst_no_early_pair", 32'(acc_cnt - acc0), 32'd0);
    send_slot(1'b0, 32'hBB, 8, 1'b0);
    check("rst_first_pair_cnt", 32'(acc_cnt - acc0), 32'd1);
    check("rst_first_left",     32'(cap_l), 32'h9900);
    check("rst_first_right",    32'(cap_r), 32'hAA00);

    // enable dropped mid-right-word with a pair pending
    out_ready = 1'b0;
    send_slot(1'b1, 32'hCC, 8, 1'b0);
    send_slot(1'b0, 32'hDD, 8, 1'b0);
    pdata = 32'hEE;
    ovr0 = ovr_cnt; acc0 = acc_cnt;
    send_bit(1'b1, carry);
    for (int j = 1; j < 4; j++) send_bit(1'b1, pdata[8-j]);
    #1 enable = 1'b0;
    for (int j = 4; j < 8; j++) send_bit(1'b1, pdata[8-j]);
    #1;
    check("dis_valid_kept", 32'(out_valid), 32'd1);
    check("dis_left_kept",  32'(out_left),  32'hBB00);
    carry = pdata[0];
    enable = 1'b1;
    send_slot(1'b0, 32'hF0, 8, 1'b0);
    check("dis_no_commit_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    check("dis_left_still",    32'(out_left),  32'hBB00);
    check("dis_right_still",   32'(out_right), 32'hCC00);
    send_slot(1'b1, 32'h0F, 8, 1'b0);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("dis_accept_valid", 32'(out_valid), 32'd0);
    check("dis_accept_left",  32'(cap_l), 32'hBB00);
    send_slot(1'b0, 32'h12, 8, 1'b0);
    check("resync_pair_cnt", 32'(acc_cnt - acc0), 32'd2);
    check("resync_left",     32'(cap_l), 32'hF000);
    check("resync_right",    32'(cap_r), 32'h0F00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
